// File: rtl/alu_pwr_seq.sv
// Power-domain sequencer and isolation wrapper for a power-gated multi-cycle ALU.
// Owns the domain's power enable, isolation enable and domain reset, drains
// in-flight work before power-down and clamps the result while isolated.
module alu_pwr_seq #(
  parameter int unsigned       WIDTH       = 16,
  parameter logic [WIDTH-1:0]  CLAMP_VALUE = '0,
  parameter int unsigned       PWRUP_CYC   = 4,
  parameter int unsigned       RST_CYC     = 2,
  parameter int unsigned       ISO_CYC     = 2,
  parameter int unsigned       DRAIN_MAX   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwr_req,
  input  logic             start_in,
  input  logic             alu_busy,
  input  logic [WIDTH-1:0] alu_result,
  output logic             start_out,
  output logic             alu_pwr_en,
  output logic             iso_en,
  output logic             alu_rst_n,
  output logic [WIDTH-1:0] result,
  output logic             pwr_ack,
  output logic [2:0]       pwr_state,
  output logic             drain_timeout
);

  // Dwell counter must hold up to (longest dwell - 1).
  localparam int unsigned MAX_A   = (PWRUP_CYC > RST_CYC) ? PWRUP_CYC : RST_CYC;
  localparam int unsigned MAX_B   = (ISO_CYC > DRAIN_MAX) ? ISO_CYC : DRAIN_MAX;
  localparam int unsigned MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  typedef enum logic [2:0] {
    S_OFF     = 3'd0,
    S_PWR_UP  = 3'd1,
    S_RST_REL = 3'd2,
    S_ON      = 3'd3,
    S_DRAIN   = 3'd4,
    S_ISO_ON  = 3'd5,
    S_PWR_DN  = 3'd6
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               timeout_q, timeout_d;
  logic               pwr_en_q, pwr_en_d;
  logic               iso_q, iso_d;
  logic               arst_n_q, arst_n_d;
  logic               ack_q, ack_d;

  // State, dwell counter, sticky timeout and decoded control flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_OFF;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      pwr_en_q  <= 1'b0;
      iso_q     <= 1'b1;
      arst_n_q  <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      pwr_en_q  <= pwr_en_d;
      iso_q     <= iso_d;
      arst_n_q  <= arst_n_d;
      ack_q     <= ack_d;
    end
  end

  // Next state, dwell counting and control decode of the next state, so the
  // control flops always equal a decode of the state register.
  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    timeout_d = timeout_q;
    pwr_en_d  = 1'b0;
    iso_d     = 1'b1;
    arst_n_d  = 1'b0;
    ack_d     = 1'b0;

    case (state_q)
      S_OFF: begin
        if (pwr_req) state_d = S_PWR_UP;
      end
      S_PWR_UP: begin
        if (cnt_q == CNT_W'(PWRUP_CYC - 1)) state_d = S_RST_REL;
        else                                 cnt_d   = cnt_q + CNT_W'(1);
      end
      S_RST_REL: begin
        if (cnt_q == CNT_W'(RST_CYC - 1)) state_d = S_ON;
        else                               cnt_d   = cnt_q + CNT_W'(1);
      end
      S_ON: begin
        if (!pwr_req) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // Idle ALU wins over a re-request; a re-request cancels a pending timeout.
        if (!alu_busy) begin
          state_d = S_ISO_ON;
        end else if (pwr_req) begin
          state_d = S_ON;
        end else if (cnt_q == CNT_W'(DRAIN_MAX - 1)) begin
          state_d   = S_ISO_ON;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_ISO_ON: begin
        if (cnt_q == CNT_W'(ISO_CYC - 1)) state_d = S_PWR_DN;
        else                               cnt_d   = cnt_q + CNT_W'(1);
      end
      S_PWR_DN: begin
        state_d = S_OFF;
      end
      default: begin
        state_d = S_OFF;
      end
    endcase

    case (state_d)
      S_PWR_UP: begin
        pwr_en_d = 1'b1;
      end
      S_RST_REL, S_ISO_ON: begin
        pwr_en_d = 1'b1;
        arst_n_d = 1'b1;
      end
      S_ON: begin
        pwr_en_d = 1'b1;
        arst_n_d = 1'b1;
        iso_d    = 1'b0;
        ack_d    = 1'b1;
      end
      S_DRAIN: begin
        pwr_en_d = 1'b1;
        arst_n_d = 1'b1;
        iso_d    = 1'b0;
      end
      default: begin
        pwr_en_d = 1'b0;
      end
    endcase
  end

  assign alu_pwr_en    = pwr_en_q;
  assign iso_en        = iso_q;
  assign alu_rst_n     = arst_n_q;
  assign pwr_ack       = ack_q;
  assign drain_timeout = timeout_q;
  assign pwr_state     = state_q;

  // Starts only reach the ALU while the domain is fully on; others are dropped.
  assign start_out = (state_q == S_ON) & start_in;

  // Isolation clamp keyed on the registered isolation enable.
  assign result = iso_q ? CLAMP_VALUE : alu_result;

endmodule

// File: tb/tb_alu_pwr_seq.sv
// Self-checking bench for alu_pwr_seq: phase/elapsed-time model plus directed checks.
module tb_alu_pwr_seq;

  localparam int unsigned W     = 16;
  localparam logic [15:0] CLAMP = 16'hDEAD;
  localparam int          PWRUP = 4;
  localparam int          RSTC  = 2;
  localparam int          ISOC  = 2;
  localparam int          DMAX  = 16;

  localparam int P_OFF = 0, P_UP = 1, P_REL = 2, P_ON = 3, P_DRAIN = 4, P_ISO = 5, P_DN = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          pwr_req;
  logic          start_in;
  logic          alu_busy;
  logic [W-1:0]  alu_result;
  logic          start_out;
  logic          alu_pwr_en;
  logic          iso_en;
  logic          alu_rst_n;
  logic [W-1:0]  result;
  logic          pwr_ack;
  logic [2:0]    pwr_state;
  logic          drain_timeout;

  int tests = 0;
  int fails = 0;

  alu_pwr_seq #(
    .WIDTH(W), .CLAMP_VALUE(CLAMP), .PWRUP_CYC(PWRUP), .RST_CYC(RSTC),
    .ISO_CYC(ISOC), .DRAIN_MAX(DMAX)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pwr_req(pwr_req), .start_in(start_in),
    .alu_busy(alu_busy), .alu_result(alu_result), .start_out(start_out),
    .alu_pwr_en(alu_pwr_en), .iso_en(iso_en), .alu_rst_n(alu_rst_n),
    .result(result), .pwr_ack(pwr_ack), .pwr_state(pwr_state),
    .drain_timeout(drain_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: current phase, edge index at which it was entered, sticky timeout.
  int m_phase = P_OFF;
  int m_entered = 0;
  int m_edge = 0;
  int m_dwell = 0;
  bit m_tout = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase   = P_OFF;
      m_tout    = 1'b0;
      m_entered = m_edge;
    end else begin
      m_edge++;
      m_dwell = m_edge - m_entered;
      case (m_phase)
        P_OFF:   if (pwr_req) begin m_phase = P_UP; m_entered = m_edge; end
        P_UP:    if (m_dwell >= PWRUP) begin m_phase = P_REL; m_entered = m_edge; end
        P_REL:   if (m_dwell >= RSTC) begin m_phase = P_ON; m_entered = m_edge; end
        P_ON:    if (!pwr_req) begin m_phase = P_DRAIN; m_entered = m_edge; end
        P_DRAIN: begin
          if (!alu_busy) begin m_phase = P_ISO; m_entered = m_edge; end
          else if (pwr_req) begin m_phase = P_ON; m_entered = m_edge; end
          else if (m_dwell >= DMAX) begin m_phase = P_ISO; m_entered = m_edge; m_tout = 1'b1; end
        end
        P_ISO:   if (m_dwell >= ISOC) begin m_phase = P_DN; m_entered = m_edge; end
        default: begin m_phase = P_OFF; m_entered = m_edge; end
      endcase
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    chk("m_state", 32'(pwr_state), 32'(m_phase));
    chk("m_pwr_en", 32'(alu_pwr_en), 32'(m_phase >= P_UP && m_phase <= P_ISO));
    chk("m_rst_n", 32'(alu_rst_n), 32'(m_phase >= P_REL && m_phase <= P_ISO));
    chk("m_iso", 32'(iso_en), 32'(!(m_phase == P_ON || m_phase == P_DRAIN)));
    chk("m_ack", 32'(pwr_ack), 32'(m_phase == P_ON));
    chk("m_start", 32'(start_out), 32'(m_phase == P_ON && start_in));
    chk("m_result", 32'(result), 32'((m_phase == P_ON || m_phase == P_DRAIN) ? alu_result : CLAMP));
    chk("m_tout", 32'(drain_timeout), 32'(m_tout));
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic chk_off_values(input string tag);
    chk({tag, "_state"}, 32'(pwr_state), 32'd0);
    chk({tag, "_pwr_en"}, 32'(alu_pwr_en), 32'd0);
    chk({tag, "_iso"}, 32'(iso_en), 32'd1);
    chk({tag, "_rst_n"}, 32'(alu_rst_n), 32'd0);
    chk({tag, "_ack"}, 32'(pwr_ack), 32'd0);
    chk({tag, "_tout"}, 32'(drain_timeout), 32'd0);
    chk({tag, "_result"}, 32'(result), 32'hDEAD);
    chk({tag, "_start"}, 32'(start_out), 32'd0);
  endtask

  initial begin
    rst_n = 1'b1; pwr_req = 1'b0; start_in = 1'b0; alu_busy = 1'b0;
    alu_result = 16'h1234;
    #1 rst_n = 1'b0;
    #1 chk_off_values("rst");
    start_in = 1'b1;
    #1 chk("rst_start", 32'(start_out), 32'd0);
    start_in = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Power-up with starts dropped during PWR_UP.
    pwr_req = 1'b1; start_in = 1'b1;
    tick(1);
    chk("up_state", 32'(pwr_state), 32'd1);
    chk("up_pwr_en", 32'(alu_pwr_en), 32'd1);
    chk("up_start", 32'(start_out), 32'd0);
    tick(3);
    chk("up_k3_rst_n", 32'(alu_rst_n), 32'd0);
    start_in = 1'b0;
    tick(1);
    chk("rel_rst_n", 32'(alu_rst_n), 32'd1);
    chk("rel_result", 32'(result), 32'hDEAD);
    tick(1);
    chk("rel_k5_ack", 32'(pwr_ack), 32'd0);
    tick(1);
    chk("on_iso", 32'(iso_en), 32'd0);
    chk("on_ack", 32'(pwr_ack), 32'd1);
    chk("on_result", 32'(result), 32'h1234);
    start_in = 1'b1;
    #1 chk("on_start", 32'(start_out), 32'd1);
    start_in = 1'b0; alu_result = 16'hA5A5;
    #1 chk("on_result2", 32'(result), 32'hA5A5);

    // Clean power-down.
    pwr_req = 1'b0; alu_busy = 1'b0;
    tick(1); chk("dn_drain", 32'(pwr_state), 32'd4);
    tick(1); chk("dn_iso_state", 32'(pwr_state), 32'd5);
    chk("dn_iso_result", 32'(result), 32'hDEAD);
    tick(1); chk("dn_iso2", 32'(pwr_state), 32'd5);
    tick(1); chk("dn_pwrdn_en", 32'(alu_pwr_en), 32'd0);
    chk("dn_pwrdn_state", 32'(pwr_state), 32'd6);
    tick(1); chk("dn_off", 32'(pwr_state), 32'd0);

    // Drain wait while busy.
    pwr_req = 1'b1; tick(7); chk("dw_on", 32'(pwr_state), 32'd3);
    pwr_req = 1'b0; alu_busy = 1'b1; start_in = 1'b1;
    tick(5);
    chk("dw_hold", 32'(pwr_state), 32'd4);
    chk("dw_iso", 32'(iso_en), 32'd0);
    chk("dw_start", 32'(start_out), 32'd0);
    alu_busy = 1'b0; start_in = 1'b0;
    tick(1);
    chk("dw_iso_on", 32'(pwr_state), 32'd5);
    chk("dw_tout", 32'(drain_timeout), 32'd0);
    tick(3); chk("dw_off", 32'(pwr_state), 32'd0);

    // Cancel, then precedence of idle over re-request.
    pwr_req = 1'b1; tick(7);
    pwr_req = 1'b0; alu_busy = 1'b1; tick(1);
    pwr_req = 1'b1; tick(1);
    chk("cancel_state", 32'(pwr_state), 32'd3);
    chk("cancel_ack", 32'(pwr_ack), 32'd1);
    pwr_req = 1'b0; tick(1);
    pwr_req = 1'b1; alu_busy = 1'b0; tick(1);
    chk("prec_state", 32'(pwr_state), 32'd5);
    pwr_req = 1'b0; tick(3);

    // Drain timeout and its stickiness.
    pwr_req = 1'b1; tick(7);
    pwr_req = 1'b0; alu_busy = 1'b1; alu_result = 16'h0F0F; tick(1);
    tick(15);
    chk("to_last_drain", 32'(pwr_state), 32'd4);
    chk("to_not_yet", 32'(drain_timeout), 32'd0);
    tick(1);
    chk("to_iso", 32'(pwr_state), 32'd5);
    chk("to_set", 32'(drain_timeout), 32'd1);
    tick(3); chk("to_off_sticky", 32'(drain_timeout), 32'd1);
    pwr_req = 1'b1; alu_busy = 1'b0; tick(7);
    chk("to_on_sticky", 32'(drain_timeout), 32'd1);

    // Async reset during ISO_ON.
    pwr_req = 1'b0; tick(2);
    chk("ar_iso_pre", 32'(pwr_state), 32'd5);
    #1 rst_n = 1'b0;
    #1 chk_off_values("ar_iso");
    #2 rst_n = 1'b1;

    // Async reset during RST_REL.
    pwr_req = 1'b1; start_in = 1'b1;
    tick(1); chk("ar_up_start", 32'(start_out), 32'd0);
    start_in = 1'b0;
    tick(4); chk("ar_rel_pre", 32'(pwr_state), 32'd2);
    #1 rst_n = 1'b0;
    #1 chk_off_values("ar_rel");
    #2 rst_n = 1'b1; pwr_req = 1'b0;
    tick(2); chk("ar_stay_off", 32'(pwr_state), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_pwr_seq.md
Name: alu_pwr_seq

Overview:
- Parametrised power-domain sequencer and isolation wrapper for a power-gated, multi-cycle ALU.
- Generalises the hard-wired pwr_en/iso_en/clamp path to a sequenced FSM that owns the ALU's power enable, isolation enable and domain reset.
- Drains in-flight operations before power-down and clamps the datapath output whenever the domain is isolated.
- Sits between the power-management request logic and the ALU instance.

Parameters:
- WIDTH, 16: width of alu_result and result.
- CLAMP_VALUE, 16'h0000: value driven on result while isolated; WIDTH bits.
- PWRUP_CYC, 4: cycles spent in PWR_UP (rail settle); must be >=1.
- RST_CYC, 2: cycles spent in RST_REL after domain reset release; must be >=1.
- ISO_CYC, 2: cycles spent in ISO_ON before the rail drops; must be >=1.
- DRAIN_MAX, 16: maximum cycles spent waiting for alu_busy low in DRAIN; must be >=1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- pwr_req  in  1  1 = ALU domain requested on, 0 = requested off
- start_in  in  1  operation start from the issuing logic
- alu_busy  in  1  busy from the ALU, meaningful only when the domain is powered
- alu_result  in  WIDTH  raw ALU result
- start_out  out  1  start forwarded to the ALU
- alu_pwr_en  out  1  power-switch enable for the ALU domain
- iso_en  out  1  isolation enable
- alu_rst_n  out  1  ALU domain reset, active-low
- result  out  WIDTH  isolated/clamped result
- pwr_ack  out  1  1 = domain on and usable
- pwr_state  out  3  current FSM state encoding
- drain_timeout  out  1  sticky: a drain ended by timeout

Behaviour:
- Reset is asynchronous, active-low.
  - Reset state: OFF, alu_pwr_en=0, iso_en=1, alu_rst_n=0, pwr_ack=0, drain_timeout=0, counter=0.
  - result=CLAMP_VALUE and start_out=0 throughout reset.
  - Reset asserted mid-sequence returns immediately to OFF values; there is no graceful drain.
- FSM encoding: OFF=0, PWR_UP=1, RST_REL=2, ON=3, DRAIN=4, ISO_ON=5, PWR_DN=6. Codes 7 and unused codes go to OFF.
- All control outputs are decoded from the registered state (Moore, glitch-free).
  - alu_pwr_en=1 in PWR_UP, RST_REL, ON, DRAIN, ISO_ON.
  - alu_rst_n=1 in RST_REL, ON, DRAIN, ISO_ON.
  - iso_en=0 only in ON and DRAIN.
  - pwr_ack=1 only in ON.
- Dwell rule: a state with parameter N occupies exactly N clock cycles. The counter loads on entry and the state exits on the edge where N cycles have elapsed.
- Transitions:
  - OFF: pwr_req=1 -> PWR_UP.
  - PWR_UP: after PWRUP_CYC -> RST_REL; pwr_req is ignored.
  - RST_REL: after RST_CYC -> ON; pwr_req is ignored.
  - ON: pwr_req=0 -> DRAIN.
  - DRAIN: alu_busy=0 -> ISO_ON. pwr_req=1 (with busy=1) -> ON. After DRAIN_MAX cycles with busy still 1 -> ISO_ON and set drain_timeout.
  - ISO_ON: after ISO_CYC -> PWR_DN; pwr_req is ignored.
  - PWR_DN: one cycle, then -> OFF. In this state alu_pwr_en=0, alu_rst_n=0, iso_en=1.
- Precedence in DRAIN: alu_busy=0 wins over a simultaneous pwr_req=1 re-assert, so power-down proceeds.
- start_out = start_in when state==ON, else 0 (combinational gate on the registered state). start_in outside ON is dropped, not queued.
- result = iso_en ? CLAMP_VALUE : alu_result. This is combinational from the registered iso_en, so X on alu_result never reaches result while isolated.
- drain_timeout is cleared only by rst_n.
- pwr_state reflects the state register.

Test Plan:
- Power-up: reset, then pwr_req=1 sampled at edge k.
  - alu_pwr_en=1 after edge k.
  - alu_rst_n=1 after edge k+4.
  - iso_en=0 and pwr_ack=1 after edge k+6.
  - result=CLAMP_VALUE until then, alu_result (e.g. 16'h1234) after.
- Clean power-down: in ON with busy=0, drop pwr_req at edge m.
  - DRAIN, then ISO_ON at m+1 (iso_en=1, result=CLAMP_VALUE).
  - PWR_DN at m+3 (alu_pwr_en=0, alu_rst_n=0).
  - OFF at m+4.
- Drain wait: drop pwr_req with alu_busy=1 for 5 cycles.
  - FSM holds in DRAIN with iso_en=0 and start_out forced 0.
  - ISO_ON on the edge after busy falls; drain_timeout stays 0.
- Drain timeout: hold alu_busy=1 indefinitely.
  - After 16 DRAIN cycles, ISO_ON is entered and drain_timeout=1.
  - drain_timeout stays 1 through OFF and a later power-up.
- Cancel and precedence:
  - In DRAIN with busy=1, re-assert pwr_req -> ON, pwr_ack=1.
  - Repeat with busy=0 and pwr_req=1 in the same cycle -> ISO_ON.
- Async reset mid-sequence: assert rst_n=0 during RST_REL and during ISO_ON.
  - Outputs go to OFF values immediately, with no clock edge.
  - start_in pulses during PWR_UP produce start_out=0.
